// File: rtl/uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_deserializer
// Purpose  : UART receive path. Oversamples the serial line at a per-frame
//            latched prescale, majority-votes three mid-bit samples per bit,
//            validates the start bit, optional parity and stop bit, and
//            presents the LSB-first assembled word with a one-cycle strobe.
// Ports    :
//   CLK        in   1           RX oversampling clock
//   RST        in   1           asynchronous reset, active-high
//   RX_IN      in   1           serial line, idle high, already synchronized
//   Prescale   in   6           oversampling ratio (8, 16 or 32)
//   PAR_EN     in   1           1 = parity bit follows the data bits
//   PAR_TYP    in   1           0 = even parity, 1 = odd parity
//   P_DATA     out  DATA_WIDTH  last good received word
//   data_valid out  1           one-cycle strobe, P_DATA valid alongside
//   par_err    out  1           parity mismatch on the last frame
//   stp_err    out  1           stop bit sampled low on the last frame
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_deserializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam logic [2:0] c_LAST_BIT = 3'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                  state_q,      state_d;
    logic [5:0]              edge_cnt_q,   edge_cnt_d;
    logic [2:0]              bit_cnt_q,    bit_cnt_d;
    logic [5:0]              presc_q,      presc_d;
    logic                    par_en_q,     par_en_d;
    logic                    par_typ_q,    par_typ_d;
    logic [2:0]              samp_q,       samp_d;
    logic [DATA_WIDTH-1:0]   shift_q,      shift_d;
    logic                    par_pend_q,   par_pend_d;
    logic [DATA_WIDTH-1:0]   p_data_q,     p_data_d;
    logic                    data_valid_q, data_valid_d;
    logic                    par_err_q,    par_err_d;
    logic                    stp_err_q,    stp_err_d;

    logic [5:0] w_presc_sel;
    logic [5:0] w_half;
    logic [5:0] w_half_m1;
    logic [5:0] w_half_p1;
    logic [5:0] w_last_edge;
    logic       w_boundary;
    logic       w_vote;
    logic       w_par_exp;

    // Anything other than the three supported ratios falls back to 8 so the
    // sample points and boundary stay well defined.
    always_comb begin
        w_presc_sel = 6'd8;
        if ((Prescale == 6'd8) || (Prescale == 6'd16) || (Prescale == 6'd32)) begin
            w_presc_sel = Prescale;
        end
    end

    assign w_half      = {1'b0, presc_q[5:1]};
    assign w_half_m1   = w_half - 6'd1;
    assign w_half_p1   = w_half + 6'd1;
    assign w_last_edge = presc_q - 6'd1;
    assign w_boundary  = (edge_cnt_q == w_last_edge);

    // All three samples are captured strictly before the boundary edge
    // (P/2+1 < P-1 for P >= 8), so the registered copies are complete here.
    assign w_vote = (samp_q[0] & samp_q[1]) |
                    (samp_q[0] & samp_q[2]) |
                    (samp_q[1] & samp_q[2]);

    // By the time PARITY is reached the shift register holds the full word.
    assign w_par_exp = (^shift_q) ^ par_typ_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= S_IDLE;
            edge_cnt_q   <= 6'd0;
            bit_cnt_q    <= 3'd0;
            presc_q      <= 6'd8;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            samp_q       <= 3'b111;
            shift_q      <= '0;
            par_pend_q   <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            presc_q      <= presc_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            samp_q       <= samp_d;
            shift_q      <= shift_d;
            par_pend_q   <= par_pend_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        presc_d      = presc_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        samp_d       = samp_q;
        shift_d      = shift_q;
        par_pend_d   = par_pend_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = par_err_q;
        stp_err_d    = stp_err_q;

        // Common bit timing for every in-frame state.
        if (state_q != S_IDLE) begin
            if (edge_cnt_q == w_half_m1) samp_d[0] = RX_IN;
            if (edge_cnt_q == w_half)    samp_d[1] = RX_IN;
            if (edge_cnt_q == w_half_p1) samp_d[2] = RX_IN;
            edge_cnt_d = w_boundary ? 6'd0 : (edge_cnt_q + 6'd1);
        end

        case (state_q)
            S_IDLE: begin
                // This edge is edge 0 of the start bit, hence edge_cnt=1 next.
                if (!RX_IN) begin
                    presc_d    = w_presc_sel;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    edge_cnt_d = 6'd1;
                    bit_cnt_d  = 3'd0;
                    par_pend_d = 1'b0;
                    par_err_d  = 1'b0;
                    stp_err_d  = 1'b0;
                    state_d    = S_START;
                end
            end

            S_START: begin
                if (w_boundary) begin
                    if (w_vote) begin
                        // Line was back high at mid-bit: a glitch, not a frame.
                        state_d = S_IDLE;
                    end else begin
                        bit_cnt_d = 3'd0;
                        state_d   = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (w_boundary) begin
                    // Shifting in from the top leaves bit k in shift[k] once
                    // all DATA_WIDTH bits have arrived.
                    shift_d = {w_vote, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == c_LAST_BIT) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end

            S_PARITY: begin
                if (w_boundary) begin
                    if (w_vote != w_par_exp) par_pend_d = 1'b1;
                    state_d = S_STOP;
                end
            end

            S_STOP: begin
                if (w_boundary) begin
                    stp_err_d = ~w_vote;
                    par_err_d = par_pend_q;
                    if (w_vote && !par_pend_q) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign P_DATA     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_deserializer
// Purpose  : Directed self-checking bench for uart_rx_deserializer. Frames are
//            serialized by a bench task; expected words and latencies are
//            queued when a good frame is sent and compared when the strobe
//            appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_deserializer;

    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RX_IN;
    logic [5:0]    Prescale;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;

    uart_rx_deserializer #(.DATA_WIDTH(DW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         lat;
        int         t0;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   n_strobe = 0;
    logic dv_prev  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Serializes one frame starting at a falling clock edge. gbit/gcyc invert
    // a single oversampling cycle of one frame bit (gbit=-1 disables it).
    task automatic send_frame(input logic [7:0] d, input int p, input bit pen,
                              input bit pbit, input bit stopb,
                              input int gbit, input int gcyc, input bit push);
        logic [11:0] bits;
        int          nb;
        bits = '1;
        nb   = 1 + DW + (pen ? 1 : 0) + 1;
        bits[0] = 1'b0;
        for (int i = 0; i < DW; i++) bits[1+i] = d[i];
        if (pen) bits[1+DW] = pbit;
        bits[nb-1] = stopb;
        if (push) begin
            exp_t e;
            e.data = d;
            e.lat  = nb * p;
            e.t0   = cyc;
            exp_q.push_back(e);
        end
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < p; c++) begin
                RX_IN = (b == gbit && c == gcyc) ? ~bits[b] : bits[b];
                @(negedge CLK);
            end
        end
        RX_IN = 1'b1;
    endtask

    // Strobe monitor / scoreboard consumer.
    always @(negedge CLK) begin
        exp_t e;
        if (dv_prev) check("dv_one_cycle", {31'd0, data_valid}, 32'd0);
        if (data_valid === 1'b1) begin
            n_strobe++;
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {31'd0, data_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("p_data", {24'd0, P_DATA}, {24'd0, e.data});
                check("latency", cyc - e.t0, e.lat);
            end
        end
        dv_prev = data_valid;
    end

    initial begin
        int s0;
        RST      = 1'b1;
        RX_IN    = 1'b1;
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_p_data", {24'd0, P_DATA}, 32'd0);
        check("rst_dv", {31'd0, data_valid}, 32'd0);
        check("rst_par_err", {31'd0, par_err}, 32'd0);
        check("rst_stp_err", {31'd0, stp_err}, 32'd0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // Good frame, P=8, even parity.
        Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        s0 = n_strobe;
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, -1, 0, 1'b1);
        @(negedge CLK);
        check("a5_strobes", n_strobe, s0 + 1);
        check("a5_par_err", {31'd0, par_err}, 32'd0);
        check("a5_stp_err", {31'd0, stp_err}, 32'd0);

        // Odd parity expected, 0 sent: parity error, word held.
        PAR_TYP = 1'b1;
        s0 = n_strobe;
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, -1, 0, 1'b0);
        @(negedge CLK);
        check("perr_par_err", {31'd0, par_err}, 32'd1);
        check("perr_stp_err", {31'd0, stp_err}, 32'd0);
        check("perr_p_data", {24'd0, P_DATA}, 32'h0000_00A5);
        check("perr_strobes", n_strobe, s0);

        // Stop error at P=16, then a good frame back-to-back.
        Prescale = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        s0 = n_strobe;
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0);
        check("serr_stp_err", {31'd0, stp_err}, 32'd1);
        check("serr_par_err", {31'd0, par_err}, 32'd0);
        check("serr_strobes", n_strobe, s0);
        fork
            send_frame(8'h81, 16, 1'b0, 1'b0, 1'b1, -1, 0, 1'b1);
            begin
                repeat (2) @(negedge CLK);
                check("serr_cleared", {31'd0, stp_err}, 32'd0);
            end
        join
        @(negedge CLK);
        check("b2b_strobes", n_strobe, s0 + 1);

        // Start glitch: 2 low cycles, idle again exactly 8 cycles later.
        Prescale = 6'd8;
        s0 = n_strobe;
        RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (6) @(negedge CLK);
        check("glitch_strobes", n_strobe, s0);
        check("glitch_par_err", {31'd0, par_err}, 32'd0);
        check("glitch_stp_err", {31'd0, stp_err}, 32'd0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, -1, 0, 1'b1);
        @(negedge CLK);
        check("post_glitch_strobes", n_strobe, s0 + 1);

        // P=32 with the mid-sample of data bit 3 inverted; config changed
        // mid-frame must be ignored.
        Prescale = 6'd32; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        s0 = n_strobe;
        fork
            send_frame(8'h55, 32, 1'b0, 1'b0, 1'b1, 4, 16, 1'b1);
            begin
                repeat (50) @(negedge CLK);
                Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b1;
            end
        join
        @(negedge CLK);
        check("noise_strobes", n_strobe, s0 + 1);
        check("noise_par_err", {31'd0, par_err}, 32'd0);

        // Reset in the middle of the data bits of 0xFF.
        Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        s0 = n_strobe;
        fork
            send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1, -1, 0, 1'b0);
            begin
                repeat (30) @(negedge CLK);
                #2 RST = 1'b1;
                #1;
                check("mrst_p_data", {24'd0, P_DATA}, 32'd0);
                check("mrst_dv", {31'd0, data_valid}, 32'd0);
                check("mrst_par_err", {31'd0, par_err}, 32'd0);
                check("mrst_stp_err", {31'd0, stp_err}, 32'd0);
                @(negedge CLK);
                RST = 1'b0;
            end
        join
        repeat (2) @(negedge CLK);
        check("mrst_strobes", n_strobe, s0);
        send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, -1, 0, 1'b1);
        @(negedge CLK);
        check("post_rst_strobes", n_strobe, s0 + 1);
        check("post_rst_p_data", {24'd0, P_DATA}, 32'h0000_0012);

        repeat (5) @(negedge CLK);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
